// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM encoding, grant
// identifiers, access size codes and the default access timeout.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } state_e;

  typedef enum logic {
    GrantFetch = 1'b0,
    GrantData  = 1'b1
  } grant_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam int unsigned TimeoutCycDefault = 16;
  // Wide enough for the largest supported timeout (255).
  localparam int unsigned TimeoutCtrWidth   = 8;

  // Round-robin pick; only meaningful when at least one request is high.
  function automatic grant_e arb_pick(input logic if_req, input logic d_req, input grant_e last);
    if (if_req && d_req) begin
      return (last == GrantData) ? GrantFetch : GrantData;
    end
    return d_req ? GrantData : GrantFetch;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating cycle counter with synchronous clear; tc_o flags the Terminal-th enabled cycle
// since the last clear.
module mem_timeout_ctr #(
  parameter int unsigned Width    = 8,
  parameter int unsigned Terminal = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [Width-1:0] LastCnt = Width'(Terminal - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count holds the number of completed enabled cycles, so Terminal-1 marks the last one.
  assign tc_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto a single RAM port with
// round-robin tie-breaking, registered RAM command and an access timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        ram_oe,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [1:0]  ram_size,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        busy
);

  state_e      state_q, state_d;
  grant_e      grant_q, grant_d;
  grant_e      last_grant_q, last_grant_d;
  grant_e      pick;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        ctr_clr, ctr_en, ctr_tc;
  logic        in_resp;

  mem_timeout_ctr #(
    .Width   (TimeoutCtrWidth),
    .Terminal(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .tc_o  (ctr_tc)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    we_d         = we_q;
    err_d        = err_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    ctr_clr      = 1'b0;
    ctr_en       = 1'b0;
    pick         = arb_pick(if_req, d_req, last_grant_q);

    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          state_d      = StAccess;
          grant_d      = pick;
          last_grant_d = pick;
          err_d        = 1'b0;
          ctr_clr      = 1'b1;
          if (pick == GrantData) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            size_d  = d_size;
            we_d    = d_we;
          end else begin
            addr_d  = if_addr;
            wdata_d = '0;
            size_d  = SizeWord;
            we_d    = 1'b0;
          end
        end
      end
      StAccess: begin
        ctr_en = 1'b1;
        // A ready in the timeout cycle still completes the access normally.
        if (ram_ready) begin
          state_d = StResp;
          err_d   = 1'b0;
          if (grant_q == GrantData) begin
            d_rdata_d = ram_rdata;
          end else begin
            if_rdata_d = ram_rdata;
          end
        end else if (ctr_tc) begin
          state_d = StResp;
          err_d   = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      grant_q      <= GrantFetch;
      last_grant_q <= GrantData;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      we_q         <= we_d;
      err_q        <= err_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign busy      = (state_q != StIdle);
  assign ram_cs    = (state_q == StAccess);
  assign ram_we    = ram_cs && we_q;
  assign ram_oe    = ram_cs && !we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_size  = size_q;

  // A timed-out fetch produces no pulse; the still-held request is simply re-granted.
  assign in_resp  = (state_q == StResp);
  assign if_ack   = in_resp && (grant_q == GrantFetch) && !err_q;
  assign d_ack    = in_resp && (grant_q == GrantData) && !err_q;
  assign d_err    = in_resp && (grant_q == GrantData) && err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  a_ack_err_excl: assert property (@(posedge clk) disable iff (!rst) !(d_ack && d_err));
  a_acks_excl:    assert property (@(posedge clk) disable iff (!rst) !(if_ack && d_ack));
  a_resp_one_cyc: assert property (@(posedge clk) disable iff (!rst)
                                   (state_q == StResp) |=> (state_q == StIdle));

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 16, maximum ACCESS cycles without ram_ready before abort (range 2..255).
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: if_req  in  1  instruction-fetch request, held high until if_ack.
REQ-005 Port: if_addr  in  32  fetch address, word access.
REQ-006 Port: if_ack / if_rdata  out  1 / 32  one-cycle completion pulse / fetched word.
REQ-007 Port: d_req, d_we  in  1, 1  data request, held until d_ack or d_err; write enable.
REQ-008 Port: d_addr, d_wdata, d_size  in  32, 32, 2  data address, store data, size (00 byte, 01 half, 10 word).
REQ-009 Port: d_ack, d_err / d_rdata  out  1, 1 / 32  completion pulse, timeout pulse / load data.
REQ-010 Port: ram_cs, ram_we, ram_oe  out  1 each  RAM strobes.
REQ-011 Port: ram_addr, ram_wdata, ram_size  out  32, 32, 2  registered RAM command.
REQ-012 Port: ram_rdata, ram_ready  in  32, 1  RAM read data, completion.
REQ-013 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-014 FSM states: IDLE, ACCESS, RESP; encoding from the shared package.
REQ-015 IDLE: any request -> latch winner's address/data/size/we into command registers, go ACCESS next edge.
REQ-016 Arbitration: single requester wins; both requesting -> requester not granted last time wins (round-robin, last_grant flag).
REQ-017 Fetch grants drive ram_size=10, ram_we=0; data grants drive d_size and d_we.
REQ-018 ACCESS: ram_cs=1, ram_oe=~ram_we, command registers stable for the entire state.
REQ-019 ACCESS with ram_ready=1 -> capture ram_rdata into the winner's rdata register, go RESP.
REQ-020 RESP: exactly one cycle; winner's ack=1, strobes 0, then IDLE; no new grant issued in RESP.
REQ-021 Latency: request first high in IDLE at edge N -> ram_cs at N+1; ram_ready sampled at edge M -> ack high for cycle M+1; minimum 3 cycles request-to-ack.
REQ-022 Timeout counter: clears on entry to ACCESS, increments each ACCESS cycle; reaching TIMEOUT_CYC without ram_ready -> RESP with err pulse instead of ack (d_err for data; fetch retries automatically from IDLE, if_ack not pulsed).
REQ-023 ram_ready and timeout in the same cycle -> ram_ready wins, normal ack.
REQ-024 ram_ready outside ACCESS is ignored.
REQ-025 Requester dropping req mid-access: access completes, ack still pulses once; if_rdata/d_rdata hold last value until the next capture.
REQ-026 ack and err never both high; if_ack and d_ack never high in the same cycle.

Reset
REQ-027 rst low: state IDLE, all strobes/acks/err/busy 0, command and rdata registers 0, timeout counter 0, last_grant = data (fetch wins first tie); effective immediately, asynchronously.
REQ-028 Reset during ACCESS aborts the access with no ack; after rst rises, first grant no earlier than the next edge.

Structure
REQ-029 Shared package holds state encoding, size codes (BYTE/HALF/WORD), and TIMEOUT_CYC default.
REQ-030 One sub-module: mem_timeout_ctr (clear, enable, terminal-count output, parameterised width).

Verification
REQ-031 Fetch only: if_addr=0x100, RAM ready 2 cycles after cs, rdata 0xE3A01005 -> ram_addr=0x100, ram_size=10, if_rdata=0xE3A01005, if_ack one cycle, total 4 cycles.
REQ-032 Simultaneous if_req and d_req after reset -> fetch granted first, data second; repeated contention alternates grants.
REQ-033 Data store d_addr=0x2000, d_wdata=0xDEADBEEF, d_size=00 -> ram_we=1, ram_oe=0, ram_size=00, d_ack one pulse.
REQ-034 Data load, ram_ready never asserted, TIMEOUT_CYC=16 -> d_err after 16 ACCESS cycles, no d_ack, FSM returns to IDLE.
REQ-035 rst low mid-ACCESS -> ram_cs drops without waiting for clk, no ack; post-reset fetch completes normally.
